// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - press/release/long-press detection and round-robin event sequencing
module btn_event_arbiter #(
  parameter int   NUM_BTN       = 4,
  parameter int   CLK_FREQ      = 50_000_000,
  parameter int   LONG_PRESS_MS = 1000,
  parameter logic ACTIVE_LEVEL  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NUM_BTN-1:0]         deb_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(NUM_BTN)-1:0] evt_id_o,
  output logic [1:0]                 evt_type_o,
  output logic [NUM_BTN-1:0]         ovf_o,
  input  logic                       ovf_clr_i
);

  localparam int IW       = $clog2(NUM_BTN);
  localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW       = $clog2(LONG_PRESS_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_PRESS_MS);

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  // Levels are normalised so that 1 always means "pressed".
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] lvl_q, lvl_d;
  logic [NUM_BTN-1:0] press, rel, long_evt, new_evt;

  logic [PW-1:0] presc_q, presc_d;
  logic          ms_tick;

  logic [HW-1:0] hold_q [NUM_BTN];
  logic [HW-1:0] hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] fired_q, fired_d;

  logic [NUM_BTN-1:0] slot_vld_q, slot_vld_d;
  logic [1:0]         slot_type_q [NUM_BTN];
  logic [1:0]         slot_type_d [NUM_BTN];
  logic [NUM_BTN-1:0] ovf_q, ovf_d;

  state_e        state_q, state_d;
  logic [IW-1:0] evt_id_q, evt_id_d;
  logic [1:0]    evt_type_q, evt_type_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        cand;
  logic               load;
  logic [NUM_BTN-1:0] grant;

  assign ms_tick     = (presc_q == PRESC_LAST);
  assign evt_valid_o = (state_q == S_HOLD);
  assign evt_id_o    = evt_id_q;
  assign evt_type_o  = evt_type_q;
  assign ovf_o       = ovf_q;

  // Edge detection, ms prescaler and per-button hold counters with one-shot long-press.
  always_comb begin
    lvl      = deb_i ^ {NUM_BTN{~ACTIVE_LEVEL}};
    lvl_d    = lvl;
    press    = lvl & ~lvl_q;
    rel      = ~lvl & lvl_q;
    long_evt = '0;
    fired_d  = fired_q;
    presc_d  = ms_tick ? '0 : presc_q + 1'b1;
    for (int b = 0; b < NUM_BTN; b++) begin
      hold_d[b] = hold_q[b];
      if (press[b]) begin
        hold_d[b]  = '0;
        fired_d[b] = 1'b0;
      end else if (lvl[b] && lvl_q[b] && ms_tick && (hold_q[b] != HOLD_MAX)) begin
        hold_d[b] = hold_q[b] + 1'b1;
        // A release this cycle clears lvl[b], so release wins over long-press.
        if ((hold_q[b] == HOLD_LAST) && !fired_q[b]) begin
          long_evt[b] = 1'b1;
          fired_d[b]  = 1'b1;
        end
      end
    end
  end

  // Round-robin search for the first pending slot starting at the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_BTN)) begin
        cand = cand - (IW+1)'(NUM_BTN);
      end
      if (!win_found && slot_vld_q[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Output register FSM: load a winner when idle or when the held event is accepted.
  always_comb begin
    state_d    = state_q;
    evt_id_d   = evt_id_q;
    evt_type_d = evt_type_q;
    ptr_d      = ptr_q;
    load       = 1'b0;
    grant      = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) load = 1'b1;
      end
      S_HOLD: begin
        if (evt_ready_i) begin
          if (win_found) load = 1'b1;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d        = S_HOLD;
      evt_id_d       = win_idx;
      evt_type_d     = slot_type_q[win_idx];
      grant[win_idx] = 1'b1;
      ptr_d          = (win_idx == IW'(NUM_BTN - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pending slots: a new event needs an empty slot or one being granted now, else it is dropped.
  always_comb begin
    new_evt = press | rel | long_evt;
    ovf_d   = ovf_clr_i ? '0 : ovf_q;
    for (int b = 0; b < NUM_BTN; b++) begin
      slot_vld_d[b]  = slot_vld_q[b];
      slot_type_d[b] = slot_type_q[b];
      if (grant[b]) slot_vld_d[b] = 1'b0;
      if (new_evt[b]) begin
        if (!slot_vld_q[b] || grant[b]) begin
          slot_vld_d[b]  = 1'b1;
          slot_type_d[b] = press[b] ? T_PRESS : (rel[b] ? T_RELEASE : T_LONG);
        end else begin
          ovf_d[b] = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards every pending and in-flight event.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lvl_q      <= '0;
      presc_q    <= '0;
      fired_q    <= '0;
      slot_vld_q <= '0;
      ovf_q      <= '0;
      state_q    <= S_IDLE;
      evt_id_q   <= '0;
      evt_type_q <= T_PRESS;
      ptr_q      <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        hold_q[b]      <= '0;
        slot_type_q[b] <= '0;
      end
    end else begin
      lvl_q      <= lvl_d;
      presc_q    <= presc_d;
      fired_q    <= fired_d;
      slot_vld_q <= slot_vld_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      evt_id_q   <= evt_id_d;
      evt_type_q <= evt_type_d;
      ptr_q      <= ptr_d;
      for (int b = 0; b < NUM_BTN; b++) begin
        hold_q[b]      <= hold_d[b];
        slot_type_q[b] <= slot_type_d[b];
      end
    end
  end

endmodule
